// File: rtl/transmissor_tabuleiro.sv
// Scans the 9x9 game board through the memory read port and streams it as
// printable ASCII rows (one char per cell, CR LF per row) over valid/ready.
module transmissor_tabuleiro #(
    parameter logic [7:0] CHAR_VAZIO = 8'h2E,
    parameter logic [7:0] CHAR_J1    = 8'h58,
    parameter logic [7:0] CHAR_J2    = 8'h4F,
    parameter logic [7:0] CHAR_INV   = 8'h3F
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    output logic [3:0] addr_macro,
    output logic [3:0] addr_micro,
    input  logic [1:0] dado_celula,
    output logic [7:0] tx_dado,
    output logic       tx_valido,
    input  logic       tx_pronto,
    output logic       ocupado,
    output logic       pronto,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        ENDERECA = 3'd1,
        LE       = 3'd2,
        ENVIA    = 3'd3,
        CR       = 3'd4,
        LF       = 3'd5,
        FIM      = 3'd6
    } estado_t;

    localparam logic [7:0] BYTE_CR = 8'h0D;
    localparam logic [7:0] BYTE_LF = 8'h0A;
    localparam logic [3:0] ULTIMO  = 4'd8;

    estado_t    estado_q, estado_d;
    logic [3:0] r_q, r_d;
    logic [3:0] c_q, c_d;
    logic [3:0] addr_macro_q, addr_macro_d;
    logic [3:0] addr_micro_q, addr_micro_d;
    logic [7:0] tx_dado_q, tx_dado_d;
    logic       tx_valido_q, tx_valido_d;
    logic       ocupado_q, ocupado_d;
    logic       pronto_q, pronto_d;

    // Counters only ever hold 0..8, so small lookup tables replace dividers.
    function automatic logic [3:0] div3(input logic [3:0] x);
        case (x)
            4'd0, 4'd1, 4'd2: div3 = 4'd0;
            4'd3, 4'd4, 4'd5: div3 = 4'd1;
            4'd6, 4'd7, 4'd8: div3 = 4'd2;
            default:          div3 = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] mod3(input logic [3:0] x);
        case (x)
            4'd0, 4'd3, 4'd6: mod3 = 4'd0;
            4'd1, 4'd4, 4'd7: mod3 = 4'd1;
            4'd2, 4'd5, 4'd8: mod3 = 4'd2;
            default:          mod3 = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] vezes3(input logic [3:0] x);
        case (x)
            4'd0:    vezes3 = 4'd0;
            4'd1:    vezes3 = 4'd3;
            4'd2:    vezes3 = 4'd6;
            default: vezes3 = 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] mapeia_char(input logic [1:0] cod);
        case (cod)
            2'b00:   mapeia_char = CHAR_VAZIO;
            2'b01:   mapeia_char = CHAR_J1;
            2'b10:   mapeia_char = CHAR_J2;
            2'b11:   mapeia_char = CHAR_INV;
            default: mapeia_char = CHAR_INV;
        endcase
    endfunction

    // Next-state, counter and output-register logic
    always_comb begin
        estado_d     = estado_q;
        r_d          = r_q;
        c_d          = c_q;
        tx_dado_d    = tx_dado_q;
        addr_macro_d = addr_macro_q;
        addr_micro_d = addr_micro_q;

        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    estado_d = ENDERECA;
                    r_d      = 4'd0;
                    c_d      = 4'd0;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            ENDERECA: begin
                estado_d = LE;
            end
            LE: begin
                tx_dado_d = mapeia_char(dado_celula);
                estado_d  = ENVIA;
            end
            ENVIA: begin
                if (tx_pronto) begin
                    if (c_q < ULTIMO) begin
                        c_d      = c_q + 4'd1;
                        estado_d = ENDERECA;
                    end else begin
                        tx_dado_d = BYTE_CR;
                        estado_d  = CR;
                    end
                end else begin
                    estado_d = ENVIA;
                end
            end
            CR: begin
                if (tx_pronto) begin
                    tx_dado_d = BYTE_LF;
                    estado_d  = LF;
                end else begin
                    estado_d = CR;
                end
            end
            LF: begin
                if (tx_pronto) begin
                    if (r_q < ULTIMO) begin
                        r_d      = r_q + 4'd1;
                        c_d      = 4'd0;
                        estado_d = ENDERECA;
                    end else begin
                        estado_d = FIM;
                    end
                end else begin
                    estado_d = LF;
                end
            end
            FIM: begin
                estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase

        // Address is loaded on entry to ENDERECA so the memory samples it that cycle.
        if (estado_d == ENDERECA) begin
            addr_macro_d = vezes3(div3(r_d)) + div3(c_d);
            addr_micro_d = vezes3(mod3(r_d)) + mod3(c_d);
        end else begin
            addr_macro_d = addr_macro_q;
            addr_micro_d = addr_micro_q;
        end

        tx_valido_d = (estado_d == ENVIA) || (estado_d == CR) || (estado_d == LF);
        ocupado_d   = (estado_d != OCIOSO);
        pronto_d    = (estado_d == FIM);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            r_q          <= 4'd0;
            c_q          <= 4'd0;
            addr_macro_q <= 4'd0;
            addr_micro_q <= 4'd0;
            tx_dado_q    <= 8'h00;
            tx_valido_q  <= 1'b0;
            ocupado_q    <= 1'b0;
            pronto_q     <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            r_q          <= r_d;
            c_q          <= c_d;
            addr_macro_q <= addr_macro_d;
            addr_micro_q <= addr_micro_d;
            tx_dado_q    <= tx_dado_d;
            tx_valido_q  <= tx_valido_d;
            ocupado_q    <= ocupado_d;
            pronto_q     <= pronto_d;
        end
    end

    assign addr_macro = addr_macro_q;
    assign addr_micro = addr_micro_q;
    assign tx_dado    = tx_dado_q;
    assign tx_valido  = tx_valido_q;
    assign ocupado    = ocupado_q;
    assign pronto     = pronto_q;
    assign db_estado  = estado_q;

endmodule
